// File: rtl/arb8_rr.sv
// arb8_rr: eight-requester round-robin arbiter with registered one-hot grant and out/flag index.
// Optional forced release after MAX_HOLD cycles is compiled in with `define ARB8_TIMEOUT_EN.
module arb8_rr #(
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] out,
  output logic       flag,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  if ((MAX_HOLD < 1) || (MAX_HOLD > 15) || ((2 ** HOLD_W) <= MAX_HOLD)) begin : g_bad_param
    $error("arb8_rr: illegal MAX_HOLD/HOLD_W combination");
  end

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [7:0] gnt_n;
  logic [2:0] out_n;
  logic       flag_n;
  logic       timeout_n;
  logic [2:0] win;
  logic       release_req;
`ifdef ARB8_TIMEOUT_EN
  logic [HOLD_W-1:0] hcnt, hcnt_n;
`endif

  // First set request bit scanning upward from p, wrapping mod 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = p + k[2:0];
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign win         = rr_pick(req, ptr);
  assign release_req = done || !req[out];

  // Next-state, pointer and output computation.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gnt_n     = gnt;
    out_n     = out;
    flag_n    = flag;
    timeout_n = 1'b0;
`ifdef ARB8_TIMEOUT_EN
    hcnt_n    = hcnt;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_n   = 8'd1 << win;
          out_n   = win;
          flag_n  = 1'b1;
          state_n = GRANT;
`ifdef ARB8_TIMEOUT_EN
          hcnt_n  = '0;
`endif
        end else begin
          gnt_n  = 8'd0;
          flag_n = 1'b0;
        end
      end
      GRANT: begin
        if (release_req) begin
          gnt_n   = 8'd0;
          flag_n  = 1'b0;
          ptr_n   = out + 3'd1;
          state_n = IDLE;
`ifdef ARB8_TIMEOUT_EN
        end else if (hcnt == HOLD_W'(MAX_HOLD - 1)) begin
          // Owner overstayed: force the release and flag it for one cycle.
          gnt_n     = 8'd0;
          flag_n    = 1'b0;
          ptr_n     = out + 3'd1;
          timeout_n = 1'b1;
          state_n   = IDLE;
        end else begin
          hcnt_n = hcnt + HOLD_W'(1);
`else
        end else begin
          gnt_n = gnt;
`endif
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 8'd0;
        flag_n  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      gnt     <= 8'd0;
      out     <= 3'd0;
      flag    <= 1'b0;
      timeout <= 1'b0;
`ifdef ARB8_TIMEOUT_EN
      hcnt    <= '0;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt     <= gnt_n;
      out     <= out_n;
      flag    <= flag_n;
      timeout <= timeout_n;
`ifdef ARB8_TIMEOUT_EN
      hcnt    <= hcnt_n;
`endif
    end
  end

endmodule

// File: doc/arb8_rr.md
# arb8_rr

Eight-requester round-robin arbiter that sequences access to one shared resource, such as the 8-input priority encoder datapath. It samples a request vector and issues a registered one-hot grant. It also reports the winning index as a 3-bit code with a valid flag, in the same out/flag form the encoder uses. It sits between the requesting units and the shared resource, holds each grant until the owner releases it, and rotates priority so that no requester starves.

## Interface
- MAX_HOLD, default 15: maximum grant length in cycles when timeout is compiled in; legal range 1..15.
- HOLD_W, default 4: hold counter width; 2**HOLD_W must exceed MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock; the only clock domain.
- rst_n  input  1  reset, synchronous, active-low.
- req  input  8  request vector; bit i is requester i, level-sensitive.
- done  input  1  release strobe from the current owner.
- gnt  output  8  registered one-hot grant; all zeros when no grant.
- out  output  3  binary index of the current owner.
- flag  output  1  grant valid; equals |gnt.
- timeout  output  1  one-cycle pulse on a forced release; constant 0 without ARB8_TIMEOUT_EN.

## Operation
- State register: IDLE or GRANT. Rotating pointer ptr[2:0]. Hold counter hcnt[HOLD_W-1:0].
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, ptr=0, hcnt=0.
  - gnt=0, out=0, flag=0, timeout=0.
  - Reset asserted during a grant drops the grant at that edge.
- IDLE:
  - If req is nonzero, select the first set bit scanning ptr, ptr+1, …, ptr+7, with indices mod 8.
  - Load gnt, out and flag with the winner, clear hcnt, and go to GRANT.
  - If req is zero, stay in IDLE with outputs zero.
- GRANT, where the owner is out:
  - Release when done=1, or when req[out]=0 because the owner withdrew.
  - On release: gnt=0, flag=0, ptr=out+1 (3-bit wrap, so 7→0), state goes to IDLE.
  - Otherwise hold the grant and increment hcnt.
  - Requests from non-owners are ignored during GRANT. They are neither latched nor queued; req is level-sensitive.
- Every release is followed by exactly one IDLE cycle with flag=0. No back-to-back grants.
- done in IDLE is ignored. done and req[out]=0 in the same cycle count as a single release.
- out holds its last value while flag=0 after the first grant. Consumers qualify out with flag.

## Timing
- Grant latency: req seen at edge N while in IDLE gives gnt/out/flag valid after edge N. Consumers see the grant in cycle N+1.
- Release latency: done=1 at edge M gives flag=0 after edge M. The earliest next grant appears after edge M+1.
- The minimum grant is 1 cycle, when done is high in the first GRANT cycle.
- Worst-case wait for requester i with all 8 requesting and everyone releasing immediately: 7×2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- ARB8_TIMEOUT_EN defined:
  - In GRANT, if hcnt==MAX_HOLD-1 and no release occurs, force a release at that edge.
  - The forced release sets gnt=0, flag=0, ptr=out+1, timeout=1 for exactly one cycle, and goes to IDLE.
  - A grant therefore lasts at most MAX_HOLD cycles.
  - If done and the limit occur in the same cycle, it is a normal release with timeout=0.
- ARB8_TIMEOUT_EN undefined:
  - The hold counter and its logic are removed.
  - timeout is tied to 0.
  - A grant lasts indefinitely while req[out]=1 and done=0.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles, then req=8'h00 for 5 cycles → gnt=8'h00, out=0, flag=0, timeout=0 throughout.
- Basic priority and rotation: from reset (ptr=0), req=8'b1000_0100.
  - The next cycle gives gnt=8'b0000_0100, out=2, flag=1.
  - Pulse done for 1 cycle → 1 cycle with flag=0, then gnt=8'b1000_0000, out=7.
  - Pulse done again, then req=8'b0000_0101 → out=0, because ptr wrapped from 7 to 0.
- Owner withdrawal: grant requester 5, drop req[5] with done=0 → flag=0 the next cycle, ptr=6. Then req=8'b0110_0000 → out=6.
- Fairness: hold req=8'hFF and pulse done in the first cycle of each grant → out sequence 0,1,2,…,7,0, with exactly one flag=0 cycle between grants.
- Timeout, compiled with ARB8_TIMEOUT_EN and MAX_HOLD=4: hold req=8'b0000_1000 and done=0.
  - flag=1 for exactly 4 cycles, then one cycle with flag=0 and timeout=1.
  - Then out=3 again, since it is the only requester.
  - Without the macro, flag stays 1 for 100+ cycles and timeout stays 0.
- Reset mid-grant: during a grant to requester 6, assert rst_n=0 for 1 cycle → after that edge gnt=0, flag=0, out=0. The next grant with req=8'hFF is out=0.
